ast_arb_mx: RTL and testbench

Avalon-ST packet arbiter-multiplexer: merges RX_DIR independent Avalon-ST sink streams into one source stream. Arbitration is round-robin and packet-granular: once an input is granted, the grant stays locked until its endofpacket beat is accepted. It is the counterpart of ast_dmx: ast_dmx fans one stream out to TX_DIR destinations, and this block shares one destination between several producers.

---
 rtl/ast_arb_mx_pkg.sv | 23 ++
 rtl/ast_arb_mx_rr_arbiter.sv | 31 +++
 rtl/ast_arb_mx.sv | 139 +++++++++++++
 tb/tb_ast_arb_mx.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ast_arb_mx_pkg.sv
// Shared types for the Avalon-ST packet arbiter-multiplexer and its bench.
package ast_arb_package;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        ONE_BEAT            = 3'd0,
        SIMUL_REQ           = 3'd1,
        LONG_PKT_RAND_READY = 3'd2,
        BACKPRESSURE        = 3'd3,
        RESET_MID_PKT       = 3'd4,
        MAIN_TEST           = 3'd5
    } test_case_t;

    // Candidate index 'offset' positions above 'base', wrapping modulo n.
    function automatic int rr_index(input int base, input int offset, input int n);
        return (base + offset) % n;
    endfunction

endpackage

// File: rtl/ast_arb_mx_rr_arbiter.sv
// Rotating-priority search: first requester strictly above last_grant wins.
module ast_rr_arbiter
    import ast_arb_package::*;
#(
    parameter int RX_DIR        = 4,
    parameter int DIR_SEL_WIDTH = (RX_DIR == 1) ? 1 : $clog2(RX_DIR)
) (
    input  logic [RX_DIR-1:0]        req,
    input  logic [DIR_SEL_WIDTH-1:0] last_grant,
    output logic [DIR_SEL_WIDTH-1:0] winner,
    output logic                     any_req
);

    logic [DIR_SEL_WIDTH-1:0] idx_s;
    logic                     hit_s;

    // Walk the inputs from last_grant+1 upward; the first hit latches.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        idx_s   = '0;
        hit_s   = 1'b0;
        for (int i = 1; i <= RX_DIR; i++) begin
            idx_s   = DIR_SEL_WIDTH'(rr_index(int'(last_grant), i, RX_DIR));
            hit_s   = !any_req && req[idx_s];
            winner  = hit_s ? idx_s : winner;
            any_req = any_req | hit_s;
        end
    end

endmodule

// File: rtl/ast_arb_mx.sv
// Packet-granular round-robin merge of RX_DIR Avalon-ST sinks into one source.
module ast_arb_mx
    import ast_arb_package::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int CHANNEL_WIDTH = 8,
    parameter int EMPTY_WIDTH   = $clog2(DATA_WIDTH / 8),
    parameter int RX_DIR        = 4,
    parameter int DIR_SEL_WIDTH = (RX_DIR == 1) ? 1 : $clog2(RX_DIR)
) (
    input  logic                     clk_i,
    input  logic                     arst_n_i,
    input  logic [DATA_WIDTH-1:0]    ast_data_i          [RX_DIR],
    input  logic [RX_DIR-1:0]        ast_startofpacket_i,
    input  logic [RX_DIR-1:0]        ast_endofpacket_i,
    input  logic [RX_DIR-1:0]        ast_valid_i,
    input  logic [EMPTY_WIDTH-1:0]   ast_empty_i         [RX_DIR],
    input  logic [CHANNEL_WIDTH-1:0] ast_channel_i       [RX_DIR],
    output logic [RX_DIR-1:0]        ast_ready_o,
    output logic [DATA_WIDTH-1:0]    ast_data_o,
    output logic                     ast_startofpacket_o,
    output logic                     ast_endofpacket_o,
    output logic                     ast_valid_o,
    output logic [EMPTY_WIDTH-1:0]   ast_empty_o,
    output logic [CHANNEL_WIDTH-1:0] ast_channel_o,
    output logic [DIR_SEL_WIDTH-1:0] ast_src_o,
    input  logic                     ast_ready_i
);

    state_t                   state_r;
    state_t                   state_nxt_s;
    logic [DIR_SEL_WIDTH-1:0] grant_r;
    logic [DIR_SEL_WIDTH-1:0] last_grant_r;
    logic [DIR_SEL_WIDTH-1:0] winner_s;
    logic                     any_req_s;
    logic                     slot_free_s;
    logic                     sink_xfer_s;
    logic                     last_beat_s;

    ast_rr_arbiter #(
        .RX_DIR        (RX_DIR),
        .DIR_SEL_WIDTH (DIR_SEL_WIDTH)
    ) u_rr_arbiter (
        .req        (ast_valid_i),
        .last_grant (last_grant_r),
        .winner     (winner_s),
        .any_req    (any_req_s)
    );

    // No skid buffer: the granted sink may only move when the output slot frees up.
    assign slot_free_s = !ast_valid_o || ast_ready_i;
    assign sink_xfer_s = (state_r == BUSY) && ast_valid_i[grant_r] && slot_free_s;
    assign last_beat_s = sink_xfer_s && ast_endofpacket_i[grant_r];

    // State register.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state: lock onto a winner, release after its endofpacket beat.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    state_nxt_s = BUSY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (last_beat_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output decode: only the granted sink sees ready, and only while BUSY.
    always_comb begin
        ast_ready_o = '0;
        case (state_r)
            BUSY:    ast_ready_o[grant_r] = slot_free_s;
            default: ast_ready_o = '0;
        endcase
    end

    // Grant bookkeeping; last_grant seeds the next rotating search.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            grant_r      <= '0;
            last_grant_r <= DIR_SEL_WIDTH'(RX_DIR - 1);
        end else begin
            if ((state_r == IDLE) && any_req_s) begin
                grant_r <= winner_s;
            end else begin
                grant_r <= grant_r;
            end
            if (last_beat_s) begin
                last_grant_r <= grant_r;
            end else begin
                last_grant_r <= last_grant_r;
            end
        end
    end

    // Output beat register, held while the downstream stalls.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            ast_valid_o         <= 1'b0;
            ast_data_o          <= '0;
            ast_startofpacket_o <= 1'b0;
            ast_endofpacket_o   <= 1'b0;
            ast_empty_o         <= '0;
            ast_channel_o       <= '0;
            ast_src_o           <= '0;
        end else if (sink_xfer_s) begin
            ast_valid_o         <= 1'b1;
            ast_data_o          <= ast_data_i[grant_r];
            ast_startofpacket_o <= ast_startofpacket_i[grant_r];
            ast_endofpacket_o   <= ast_endofpacket_i[grant_r];
            ast_empty_o         <= ast_empty_i[grant_r];
            ast_channel_o       <= ast_channel_i[grant_r];
            ast_src_o           <= grant_r;
        end else if (ast_ready_i) begin
            ast_valid_o         <= 1'b0;
        end else begin
            ast_valid_o         <= ast_valid_o;
        end
    end

endmodule

// File: tb/tb_ast_arb_mx.sv
// Randomized self-checking bench for ast_arb_mx with a per-source packet scoreboard.
`timescale 1ns/1ps
module tb_ast_arb_mx;
    import ast_arb_package::*;

    localparam int RX = 4;
    localparam int DW = 64;
    localparam int CW = 8;
    localparam int EW = 3;
    localparam int SW = 2;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic [EW-1:0] empty;
        logic [CW-1:0] chan;
    } beat_t;

    logic          clk = 1'b0;
    logic          arst_n = 1'b0;
    logic [DW-1:0] data_i [RX];
    logic [RX-1:0] sop_i, eop_i, valid_i, ready_o;
    logic [EW-1:0] empty_i [RX];
    logic [CW-1:0] chan_i [RX];
    logic [DW-1:0] data_o;
    logic          sop_o, eop_o, valid_o, ready_i;
    logic [EW-1:0] empty_o;
    logic [CW-1:0] chan_o;
    logic [SW-1:0] src_o;

    int         chk_cnt = 0;
    int         pass_cnt = 0;
    test_case_t tc = ONE_BEAT;
    beat_t      gen_q [RX][$];
    beat_t      exp_q [RX][$];
    int         gap_cnt [RX];
    int         wait_cnt [RX];
    bit         waiting [RX];
    int         sink_cnt [RX];
    int         out_src_q [$];
    int         out_cyc_q [$];
    int         ready_pct = 100;
    int         gap_pct = 0;
    int         cyc = 0;
    bit         out_in_pkt;
    int         out_cur;
    bit         prev_stall;
    beat_t      prev_beat;
    logic [SW-1:0] prev_src;
    bit         bp_check;

    always #5 clk = ~clk;

    ast_arb_mx #(
        .DATA_WIDTH(DW), .CHANNEL_WIDTH(CW), .EMPTY_WIDTH(EW), .RX_DIR(RX), .DIR_SEL_WIDTH(SW)
    ) dut (
        .clk_i               (clk),
        .arst_n_i            (arst_n),
        .ast_data_i          (data_i),
        .ast_startofpacket_i (sop_i),
        .ast_endofpacket_i   (eop_i),
        .ast_valid_i         (valid_i),
        .ast_empty_i         (empty_i),
        .ast_channel_i       (chan_i),
        .ast_ready_o         (ready_o),
        .ast_data_o          (data_o),
        .ast_startofpacket_o (sop_o),
        .ast_endofpacket_o   (eop_o),
        .ast_valid_o         (valid_o),
        .ast_empty_o         (empty_o),
        .ast_channel_o       (chan_o),
        .ast_src_o           (src_o),
        .ast_ready_i         (ready_i)
    );

    function automatic beat_t out_beat();
        beat_t b;
        b.data = data_o; b.sop = sop_o; b.eop = eop_o; b.empty = empty_o; b.chan = chan_o;
        return b;
    endfunction

    function automatic bit pending();
        for (int k = 0; k < RX; k++)
            if (gen_q[k].size() != 0 || exp_q[k].size() != 0) return 1'b1;
        return valid_o;
    endfunction

    // Reference model: every generated beat must leave in per-source order.
    task automatic gen_pkt(input int k, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data  = {$urandom, $urandom};
            b.sop   = (i == 0);
            b.eop   = (i == len - 1);
            b.empty = EW'($urandom_range(0, 7));
            b.chan  = CW'($urandom_range(0, 255));
            gen_q[k].push_back(b);
            exp_q[k].push_back(b);
        end
    endtask

    task automatic clear_model();
        valid_i = '0; sop_i = '0; eop_i = '0;
        for (int k = 0; k < RX; k++) begin
            data_i[k] = '0; empty_i[k] = '0; chan_i[k] = '0;
            gen_q[k].delete(); exp_q[k].delete();
            gap_cnt[k] = 0; wait_cnt[k] = 0; waiting[k] = 1'b0; sink_cnt[k] = 0;
        end
        out_src_q.delete(); out_cyc_q.delete();
        out_in_pkt = 1'b0; out_cur = 0; prev_stall = 1'b0; bp_check = 1'b0;
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        ready_i = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One clock of traffic: drive sinks, score the output at negedge, retire accepted beats.
    task automatic cycle();
        beat_t b;
        bit    sx [RX];
        int    s;
        for (int k = 0; k < RX; k++) begin
            if (!valid_i[k]) begin
                if (gap_cnt[k] > 0) gap_cnt[k]--;
                else if (gen_q[k].size() > 0) begin
                    b = gen_q[k][0];
                    data_i[k] = b.data; sop_i[k] = b.sop; eop_i[k] = b.eop;
                    empty_i[k] = b.empty; chan_i[k] = b.chan; valid_i[k] = 1'b1;
                    if (b.sop) waiting[k] = 1'b1;
                end
            end
        end
        ready_i = ($urandom_range(0, 99) < ready_pct);
        @(negedge clk);
        chk_cnt++;
        if ($countones(ready_o) > 1) $display("FAIL %s ready_onehot got=%b expected at most one bit", tc.name(), ready_o);
        else pass_cnt++;
        if (prev_stall) begin
            chk_cnt++;
            if (out_beat() !== prev_beat || src_o !== prev_src || valid_o !== 1'b1)
                $display("FAIL %s stall_hold got=%h/%0d expected=%h/%0d", tc.name(), out_beat(), src_o, prev_beat, prev_src);
            else pass_cnt++;
        end
        if (bp_check) begin
            chk_cnt++;
            if (ready_o !== 4'b0000 || valid_o !== 1'b1)
                $display("FAIL %s bp_ready got ready_o=%b valid_o=%b expected 0000/1", tc.name(), ready_o, valid_o);
            else pass_cnt++;
        end
        prev_beat = out_beat(); prev_src = src_o; prev_stall = valid_o && !ready_i;
        if (valid_o && ready_i) begin
            s = int'(src_o);
            chk_cnt++;
            if (exp_q[s].size() == 0) $display("FAIL %s unexpected_beat src=%0d got=%h expected none", tc.name(), s, out_beat());
            else begin
                b = exp_q[s].pop_front();
                if (out_beat() !== b) $display("FAIL %s beat src=%0d got=%h expected=%h", tc.name(), s, out_beat(), b);
                else pass_cnt++;
            end
            chk_cnt++;
            if (out_in_pkt && s != out_cur) $display("FAIL %s interleave got src=%0d expected src=%0d", tc.name(), s, out_cur);
            else pass_cnt++;
            out_cyc_q.push_back(cyc);
            if (sop_o) begin waiting[s] = 1'b0; wait_cnt[s] = 0; end
            if (eop_o) begin
                out_src_q.push_back(s);
                out_in_pkt = 1'b0;
                for (int k = 0; k < RX; k++) begin
                    if (k != s && waiting[k]) begin
                        wait_cnt[k]++;
                        chk_cnt++;
                        if (wait_cnt[k] > RX) $display("FAIL %s fairness src=%0d waited=%0d expected<=%0d", tc.name(), k, wait_cnt[k], RX);
                        else pass_cnt++;
                    end
                end
            end else begin
                out_in_pkt = 1'b1; out_cur = s;
            end
        end
        for (int k = 0; k < RX; k++) sx[k] = valid_i[k] && ready_o[k];
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < RX; k++) begin
            if (sx[k]) begin
                void'(gen_q[k].pop_front());
                valid_i[k] = 1'b0;
                sink_cnt[k]++;
                gap_cnt[k] = ($urandom_range(0, 99) < gap_pct) ? int'($urandom_range(1, 3)) : 0;
            end
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (pending() && n < budget) begin cycle(); n++; end
        chk_cnt++;
        if (pending()) $display("FAIL %s drain_timeout got pending after %0d cycles expected drained", tc.name(), n);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        ready_i = 1'b1;
        clear_model();
        @(negedge clk);
        chk_cnt++;
        if ({valid_o, sop_o, eop_o} !== 3'b000 || data_o !== '0 || empty_o !== '0 || chan_o !== '0 || src_o !== '0 || ready_o !== '0)
            $display("FAIL reset_values got v=%b d=%h e=%0d c=%0d s=%0d r=%b expected all zero", valid_o, data_o, empty_o, chan_o, src_o, ready_o);
        else pass_cnt++;
        arst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_cnt++;
        if (valid_o !== 1'b0 || ready_o !== 4'b0000)
            $display("FAIL reset_idle got valid_o=%b ready_o=%b expected 0/0000", valid_o, ready_o);
        else pass_cnt++;
    endtask

    task automatic test_one_beat();
        tc = ONE_BEAT;
        do_reset();
        ready_i = 1'b1;
        data_i[2] = 64'h0000_0000_0000_00A5; sop_i[2] = 1'b1; eop_i[2] = 1'b1;
        empty_i[2] = 3'd3; chan_i[2] = 8'd7; valid_i[2] = 1'b1;
        #1;
        chk_cnt++;
        if (ready_o !== 4'b0000) $display("FAIL %s idle_ready got=%b expected=0000", tc.name(), ready_o);
        else pass_cnt++;
        @(posedge clk); #1;
        chk_cnt++;
        if (ready_o !== 4'b0100 || valid_o !== 1'b0)
            $display("FAIL %s n1 got ready_o=%b valid_o=%b expected 0100/0", tc.name(), ready_o, valid_o);
        else pass_cnt++;
        @(posedge clk); #1;
        valid_i[2] = 1'b0;
        chk_cnt++;
        if (valid_o !== 1'b1 || data_o !== 64'h0000_0000_0000_00A5 || empty_o !== 3'd3 || chan_o !== 8'd7 || src_o !== 2'd2 || sop_o !== 1'b1 || eop_o !== 1'b1)
            $display("FAIL %s n2 got v=%b d=%h e=%0d c=%0d s=%0d expected 1/a5/3/7/2", tc.name(), valid_o, data_o, empty_o, chan_o, src_o);
        else pass_cnt++;
        @(posedge clk); #1;
        chk_cnt++;
        if (valid_o !== 1'b0) $display("FAIL %s n3 got valid_o=%b expected=0", tc.name(), valid_o);
        else pass_cnt++;
    endtask

    task automatic test_simul_req();
        tc = SIMUL_REQ;
        do_reset();
        ready_pct = 100; gap_pct = 0;
        for (int k = 0; k < RX; k++) gen_pkt(k, 1);
        drain(50);
        chk_cnt++;
        if (out_src_q.size() != RX) $display("FAIL %s pkt_count got=%0d expected=%0d", tc.name(), out_src_q.size(), RX);
        else pass_cnt++;
        for (int i = 0; i < out_src_q.size(); i++) begin
            chk_cnt++;
            if (out_src_q[i] != i) $display("FAIL %s order[%0d] got=%0d expected=%0d", tc.name(), i, out_src_q[i], i);
            else pass_cnt++;
            if (i > 0) begin
                chk_cnt++;
                if (out_cyc_q[i] - out_cyc_q[i-1] != 2)
                    $display("FAIL %s spacing[%0d] got=%0d expected=2", tc.name(), i, out_cyc_q[i] - out_cyc_q[i-1]);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_long_pkt_rand_ready();
        tc = LONG_PKT_RAND_READY;
        do_reset();
        ready_pct = 50; gap_pct = 0;
        gen_pkt(1, 20);
        gen_pkt(3, 3);
        drain(400);
        chk_cnt++;
        if (out_src_q.size() != 2 || out_src_q[0] != 1 || out_src_q[1] != 3)
            $display("FAIL %s order got size=%0d first=%0d expected 2 packets 1 then 3", tc.name(), out_src_q.size(),
                     (out_src_q.size() > 0) ? out_src_q[0] : -1);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int n = 0;
        tc = BACKPRESSURE;
        do_reset();
        ready_pct = 100; gap_pct = 0;
        gen_pkt(0, 8);
        while (out_cyc_q.size() < 2 && n < 20) begin cycle(); n++; end
        ready_pct = 0;
        bp_check = 1'b1;
        repeat (10) cycle();
        bp_check = 1'b0;
        ready_pct = 100;
        drain(100);
        chk_cnt++;
        if (out_cyc_q.size() != 8 || sink_cnt[0] != 8)
            $display("FAIL %s beat_count got out=%0d in=%0d expected 8/8", tc.name(), out_cyc_q.size(), sink_cnt[0]);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_pkt();
        int n = 0;
        tc = RESET_MID_PKT;
        do_reset();
        ready_pct = 100; gap_pct = 0;
        gen_pkt(2, 6);
        while (sink_cnt[2] < 2 && n < 20) begin cycle(); n++; end
        chk_cnt++;
        if (sink_cnt[2] != 2) $display("FAIL %s pre_reset_beats got=%0d expected=2", tc.name(), sink_cnt[2]);
        else pass_cnt++;
        arst_n = 1'b0;
        #1;
        chk_cnt++;
        if ({valid_o, sop_o, eop_o} !== 3'b000 || data_o !== '0 || empty_o !== '0 || chan_o !== '0 || src_o !== '0 || ready_o !== '0)
            $display("FAIL %s async_clear got v=%b d=%h s=%0d r=%b expected all zero", tc.name(), valid_o, data_o, src_o, ready_o);
        else pass_cnt++;
        clear_model();
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk); #1;
        gen_pkt(0, 1);
        gen_pkt(2, 1);
        drain(50);
        chk_cnt++;
        if (out_src_q.size() != 2 || out_src_q[0] != 0 || out_src_q[1] != 2)
            $display("FAIL %s restart_order got size=%0d first=%0d expected 0 then 2", tc.name(), out_src_q.size(),
                     (out_src_q.size() > 0) ? out_src_q[0] : -1);
        else pass_cnt++;
    endtask

    task automatic test_main();
        tc = MAIN_TEST;
        do_reset();
        ready_pct = 85; gap_pct = 10;
        for (int p = 0; p < 1000; p++) gen_pkt(int'($urandom_range(0, RX - 1)), int'($urandom_range(1, 64)));
        drain(80000);
        chk_cnt++;
        if (out_src_q.size() != 1000) $display("FAIL %s pkt_count got=%0d expected=1000", tc.name(), out_src_q.size());
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_one_beat();
        test_simul_req();
        test_long_pkt_rand_ready();
        test_backpressure();
        test_reset_mid_pkt();
        test_main();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
